// File: rtl/tm_pkg.sv
// rtl/tm_pkg.sv - shared constants and types for the TuringMachine tape driver
// Purpose: default widths/depth and the driver FSM state type.
// Ports: none (package).
package tm_pkg;
    localparam int SYM_W  = 4;
    localparam int DEPTH  = 64;
    localparam int DISP_W = 11;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        DONE,
        WAIT
    } tm_drv_state_t;

    typedef logic [SYM_W-1:0] tm_sym_t;
endpackage

// File: rtl/tm_tape_buf.sv
// rtl/tm_tape_buf.sv - DEPTH x SYM_W tape symbol store
// Purpose: register array holding the host-written tape; contents are not reset.
// Ports:
//   clock      in   system clock
//   we         in   write enable
//   waddr      in   write index
//   wdata      in   symbol to store
//   raddr      in   read index
//   rdata      out  symbol at raddr (combinational)
module tm_tape_buf #(
    parameter int SYM_W = 4,
    parameter int DEPTH = 64,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [SYM_W-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [SYM_W-1:0] rdata
);
    logic [SYM_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/tm_tape_driver.sv
// rtl/tm_tape_driver.sv - host-side tape loader and result capture for TuringMachine
// Purpose: buffers host symbols, replays them as data+Next pulses on start, issues Done,
//          then waits for Compute_done (or a timeout) and captures the display word.
// Ports:
//   clock, reset        in   clock, synchronous active-high reset
//   wr_valid/wr_data    in   host symbol append; wr_ready out (IDLE and not full)
//   clear, start        in   empty buffer / begin run (IDLE only; start beats clear beats write)
//   count, busy         out  symbols buffered, not-IDLE
//   tm_data/tm_next/tm_done  out  TuringMachine input_data/Next/Done
//   tm_compute_done/tm_display in  TuringMachine Compute_done/display_out
//   result/result_valid/timed_out  out  captured word, capture valid, last run timed out
module tm_tape_driver
    import tm_pkg::*;
#(
    parameter int SYM_W     = tm_pkg::SYM_W,
    parameter int DEPTH     = tm_pkg::DEPTH,
    parameter int DISP_W    = tm_pkg::DISP_W,
    parameter int SETUP_CYC = 1,
    parameter int TIMEOUT   = 1024
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wr_valid,
    input  logic [SYM_W-1:0]           wr_data,
    output logic                       wr_ready,
    input  logic                       clear,
    input  logic                       start,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       busy,
    output logic [SYM_W-1:0]           tm_data,
    output logic                       tm_next,
    output logic                       tm_done,
    input  logic                       tm_compute_done,
    input  logic [DISP_W-1:0]          tm_display,
    output logic [DISP_W-1:0]          result,
    output logic                       result_valid,
    output logic                       timed_out
);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SC_W  = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    tm_drv_state_t    state;
    logic [CNT_W-1:0] rd_idx;
    logic [CNT_W-1:0] rd_idx_inc;
    logic [SC_W-1:0]  setup_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic             we;
    logic [AW-1:0]    raddr;
    logic [SYM_W-1:0] rdata;

    assign busy       = (state != IDLE);
    assign wr_ready   = (state == IDLE) && (count < CNT_W'(DEPTH));
    assign we         = wr_valid && wr_ready && !clear && !start;
    assign rd_idx_inc = rd_idx + CNT_W'(1);
    // tm_data is registered on entry to SETUP, so the read port looks one symbol
    // ahead: index 0 when leaving IDLE, rd_idx+1 when leaving PULSE.
    assign raddr      = (state == IDLE) ? '0 : rd_idx_inc[AW-1:0];

    tm_tape_buf #(
        .SYM_W (SYM_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buf (
        .clock (clock),
        .we    (we),
        .waddr (count[AW-1:0]),
        .wdata (wr_data),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            rd_idx       <= '0;
            setup_cnt    <= '0;
            to_cnt       <= '0;
            tm_data      <= '0;
            tm_next      <= 1'b0;
            tm_done      <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            timed_out    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rd_idx       <= '0;
                        setup_cnt    <= '0;
                        result_valid <= 1'b0;
                        timed_out    <= 1'b0;
                        if (count != '0) begin
                            state   <= SETUP;
                            tm_data <= rdata;
                        end else begin
                            state   <= DONE;
                            tm_done <= 1'b1;
                            to_cnt  <= '0;
                        end
                    end else if (clear) begin
                        count <= '0;
                    end else if (we) begin
                        count <= count + CNT_W'(1);
                    end
                end
                SETUP: begin
                    if (setup_cnt == SC_W'(SETUP_CYC - 1)) begin
                        setup_cnt <= '0;
                        tm_next   <= 1'b1;
                        state     <= PULSE;
                    end else begin
                        setup_cnt <= setup_cnt + SC_W'(1);
                    end
                end
                PULSE: begin
                    tm_next <= 1'b0;
                    rd_idx  <= rd_idx_inc;
                    if (rd_idx_inc == count) begin
                        state   <= DONE;
                        tm_done <= 1'b1;
                        tm_data <= '0;
                        to_cnt  <= '0;
                    end else begin
                        state   <= SETUP;
                        tm_data <= rdata;
                    end
                end
                DONE: begin
                    tm_done <= 1'b0;
                    state   <= WAIT;
                end
                WAIT: begin
                    // Completion wins over a timeout expiring on the same cycle.
                    if (tm_compute_done) begin
                        result       <= tm_display;
                        result_valid <= 1'b1;
                        state        <= IDLE;
                    end else if ((TIMEOUT > 0) && (to_cnt == TO_W'(TIMEOUT - 1))) begin
                        timed_out <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tm_tape_driver.sv
// tb/tb_tm_tape_driver.sv - self-checking bench for tm_tape_driver
module tb_tm_tape_driver;
    localparam int SYM_W     = 4;
    localparam int DEPTH     = 64;
    localparam int DISP_W    = 11;
    localparam int SETUP_CYC = 1;
    localparam int TIMEOUT   = 16;
    localparam int CNT_W     = $clog2(DEPTH+1);

    logic               clock;
    logic               reset;
    logic               wr_valid;
    logic [SYM_W-1:0]   wr_data;
    logic               wr_ready;
    logic               clear;
    logic               start;
    logic [CNT_W-1:0]   count;
    logic               busy;
    logic [SYM_W-1:0]   tm_data;
    logic               tm_next;
    logic               tm_done;
    logic               tm_compute_done;
    logic [DISP_W-1:0]  tm_display;
    logic [DISP_W-1:0]  result;
    logic               result_valid;
    logic               timed_out;

    int n_cmp;
    int n_fail;
    logic [SYM_W-1:0] model[$];

    tm_tape_driver #(
        .SYM_W     (SYM_W),
        .DEPTH     (DEPTH),
        .DISP_W    (DISP_W),
        .SETUP_CYC (SETUP_CYC),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .wr_valid        (wr_valid),
        .wr_data         (wr_data),
        .wr_ready        (wr_ready),
        .clear           (clear),
        .start           (start),
        .count           (count),
        .busy            (busy),
        .tm_data         (tm_data),
        .tm_next         (tm_next),
        .tm_done         (tm_done),
        .tm_compute_done (tm_compute_done),
        .tm_display      (tm_display),
        .result          (result),
        .result_valid    (result_valid),
        .timed_out       (timed_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero;
        chk("rst_tm_data", 32'(tm_data), 0);
        chk("rst_tm_next", 32'(tm_next), 0);
        chk("rst_tm_done", 32'(tm_done), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_result_valid", 32'(result_valid), 0);
        chk("rst_timed_out", 32'(timed_out), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_count", 32'(count), 0);
    endtask

    task automatic wr(input logic [SYM_W-1:0] v);
        bit rdy;
        rdy = model.size() < DEPTH;
        wr_valid = 1'b1;
        wr_data  = v;
        chk("wr_ready", 32'(wr_ready), 32'(rdy));
        tick;
        wr_valid = 1'b0;
        if (rdy) model.push_back(v);
        chk("count_after_wr", 32'(count), 32'(model.size()));
    endtask

    task automatic do_clear(input bit with_write);
        clear    = 1'b1;
        wr_valid = with_write;
        wr_data  = 4'(($urandom));
        tick;
        clear    = 1'b0;
        wr_valid = 1'b0;
        model.delete();
        chk("count_after_clear", 32'(count), 0);
    endtask

    // One full run; expected tm_* waveforms come from the symbol period arithmetic:
    // symbol i occupies cycles i*(S+1)+1 .. (i+1)*(S+1), Next on the last of those,
    // Done on cycle N*(S+1)+1 (cycle 0 = the cycle start is presented).
    task automatic run(input int wait_cyc, input bit pre_high, input bit do_timeout,
                       input bit with_clear, input int reset_at, input logic [DISP_W-1:0] dval);
        int n, per, last;
        logic [SYM_W-1:0] ed;
        bit en;
        n    = model.size();
        per  = SETUP_CYC + 1;
        last = n * per + 1;
        start = 1'b1;
        clear = with_clear;
        tick;
        start = 1'b0;
        clear = 1'b0;
        for (int c = 1; c <= last; c++) begin
            if (c < last) begin
                ed = model[(c - 1) / per];
                en = (c % per) == 0;
            end else begin
                ed = '0;
                en = 1'b0;
            end
            chk("tm_data", 32'(tm_data), 32'(ed));
            chk("tm_next", 32'(tm_next), 32'(en));
            chk("tm_done", 32'(tm_done), 32'(c == last));
            chk("busy_run", 32'(busy), 1);
            if (c == 1) begin
                chk("result_valid_cleared", 32'(result_valid), 0);
                chk("timed_out_cleared", 32'(timed_out), 0);
            end
            if (c == reset_at) begin
                wr_valid = 1'b0;
                start    = 1'b0;
                clear    = 1'b0;
                reset    = 1'b1;
                tick;
                reset    = 1'b0;
                chk_zero();
                model.delete();
                return;
            end
            if (c < last) begin
                // host noise while busy must have no effect
                wr_valid = 1'($urandom);
                wr_data  = 4'($urandom);
                clear    = 1'($urandom);
                start    = 1'($urandom);
            end else begin
                wr_valid = 1'b0;
                clear    = 1'b0;
                start    = 1'b0;
                if (pre_high) begin
                    tm_compute_done = 1'b1;
                    tm_display      = dval;
                end
            end
            tick;
        end
        if (do_timeout) begin
            for (int w = 1; w <= TIMEOUT; w++) begin
                chk("busy_wait", 32'(busy), 1);
                chk("tm_data_wait", 32'(tm_data), 0);
                chk("tm_next_wait", 32'(tm_next), 0);
                chk("tm_done_wait", 32'(tm_done), 0);
                tick;
            end
            chk("busy_after_timeout", 32'(busy), 0);
            chk("timed_out", 32'(timed_out), 1);
            chk("result_valid_timeout", 32'(result_valid), 0);
            chk("count_after_timeout", 32'(count), 32'(model.size()));
            return;
        end
        if (pre_high) begin
            chk("busy_wait_entry", 32'(busy), 1);
            chk("result_valid_wait_entry", 32'(result_valid), 0);
            tick;
        end else begin
            for (int w = 0; w < wait_cyc; w++) begin
                chk("busy_wait", 32'(busy), 1);
                tick;
            end
            tm_compute_done = 1'b1;
            tm_display      = dval;
            tick;
        end
        tm_compute_done = 1'b0;
        tm_display      = 11'($urandom);
        chk("result", 32'(result), 32'(dval));
        chk("result_valid", 32'(result_valid), 1);
        chk("busy_after_run", 32'(busy), 0);
        chk("timed_out_ok", 32'(timed_out), 0);
        chk("count_after_run", 32'(count), 32'(model.size()));
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset           = 1'b1;
        wr_valid        = 1'b0;
        wr_data         = '0;
        clear           = 1'b0;
        start           = 1'b0;
        tm_compute_done = 1'b0;
        tm_display      = '0;
        tick;
        tick;
        chk_zero();
        reset = 1'b0;
        tick;
        chk("wr_ready_idle", 32'(wr_ready), 1);

        // 3,A,F replay, completion after 4 WAIT cycles, then identical second replay
        wr(4'h3);
        wr(4'hA);
        wr(4'hF);
        run(4, 1'b0, 1'b0, 1'b0, 0, 11'h5A5);
        run(0, 1'b1, 1'b0, 1'b1, 0, 11'($urandom));

        // clear beats a same-cycle write; empty start goes straight to Done
        do_clear(1'b1);
        run(2, 1'b0, 1'b0, 1'b0, 0, 11'($urandom));

        // fill to DEPTH, overflow write dropped, full replay
        for (int i = 0; i < DEPTH; i++) wr(4'($urandom));
        chk("wr_ready_full", 32'(wr_ready), 0);
        wr(4'($urandom));
        run(1, 1'b0, 1'b0, 1'b0, 0, 11'($urandom));

        // timeout
        do_clear(1'b0);
        wr(4'($urandom));
        wr(4'($urandom));
        run(0, 1'b0, 1'b1, 1'b0, 0, '0);

        // reset during the Next pulse of symbol 2
        do_clear(1'b0);
        wr(4'h1);
        wr(4'h2);
        wr(4'h3);
        run(0, 1'b0, 1'b0, 1'b0, 2 * (SETUP_CYC + 1), '0);

        // randomized tapes
        for (int r = 0; r < 8; r++) begin
            int nw;
            if ($urandom_range(0, 2) == 0) do_clear(1'($urandom));
            nw = $urandom_range(0, 6);
            for (int k = 0; k < nw; k++) wr(4'($urandom));
            run($urandom_range(0, TIMEOUT - 4), 1'($urandom), 1'b0, 1'($urandom), 0,
                11'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed still running expected finished");
        $fatal(1, "watchdog");
    end
endmodule
